// File: rtl/chan_sum_maxpool.sv
// ---------------------------------------------------------------------------
// chan_sum_maxpool
//
// Purpose
//   Channel-reduce, bias, saturate, optional ReLU and PxP max-pool stage of
//   the CNN pipeline. IN_CH signed channel samples of one pixel are summed
//   with a signed bias. The sum is saturated to OUT_BITS and optionally
//   clamped at zero. The pixel stream is then max-pooled over a raster-ordered
//   WIDTH x HEIGHT map with window edge and stride POOL.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   frame_rst   synchronous restart of counters, window state and S1 valid
//   relu_en     1: negative sums become 0 (sampled with in_val)
//   in_val      data_in/bias carry one pixel this cycle
//   data_in     IN_CH signed samples, channel c at [c*IN_BITS +: IN_BITS]
//   bias        signed bias, sampled with every in_val
//   data_out    signed pooled result (held between pulses)
//   out_val     one-cycle pulse, data_out valid
//   frame_done  pulses together with the last pooled output of a frame
//
// Pipeline
//   S1 registers the saturated/ReLU'd pixel value. S2 advances the raster
//   counters, tracks the horizontal running max and the per-window vertical
//   max in a small row buffer, and registers the pooled output. out_val
//   therefore rises two cycles after the in_val of a window's last pixel.
// ---------------------------------------------------------------------------
module chan_sum_maxpool #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int IN_CH     = 3,
  parameter int IN_BITS   = 18,
  parameter int BIAS_BITS = 8,
  parameter int OUT_BITS  = 20,
  parameter int POOL      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_rst,
  input  logic                     relu_en,
  input  logic                     in_val,
  input  logic [IN_CH*IN_BITS-1:0] data_in,
  input  logic [BIAS_BITS-1:0]     bias,
  output logic [OUT_BITS-1:0]      data_out,
  output logic                     out_val,
  output logic                     frame_done
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int MAX_IN_W = (IN_BITS > BIAS_BITS) ? IN_BITS : BIAS_BITS;
  localparam int SUM_W    = MAX_IN_W + $clog2(IN_CH + 1) + 1;

  localparam int PW  = WIDTH / POOL;   // pooled columns
  localparam int PH  = HEIGHT / POOL;  // pooled rows
  localparam int CW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PCW = (POOL   > 1) ? $clog2(POOL)   : 1;
  localparam int AW  = (PW     > 1) ? $clog2(PW)     : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
  // Last column/row that still belongs to a complete pooling window.
  localparam logic [CW-1:0]  COL_LIM  = CW'(PW * POOL - 1);
  localparam logic [RW-1:0]  ROW_LIM  = RW'(PH * POOL - 1);
  localparam logic [PCW-1:0] P_LAST   = PCW'(POOL - 1);
  localparam logic [CW-1:0]  POOL_C   = CW'(POOL);

  function automatic logic signed [OUT_BITS-1:0] smax(
    input logic signed [OUT_BITS-1:0] a,
    input logic signed [OUT_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // -------------------------------------------------------------------------
  // S1: channel sum + bias, saturation, ReLU
  // -------------------------------------------------------------------------
  logic signed [SUM_W-1:0]    ch_ext [IN_CH];
  logic signed [SUM_W-1:0]    bias_ext;
  logic signed [SUM_W-1:0]    sum;
  logic signed [OUT_BITS-1:0] sat;
  logic signed [OUT_BITS-1:0] v_d;
  logic signed [OUT_BITS-1:0] v_q;
  logic                       s1_val_d;
  logic                       s1_val_q;

  genvar gi;
  generate
    for (gi = 0; gi < IN_CH; gi++) begin : g_ch
      logic [IN_BITS-1:0] raw;
      assign raw        = data_in[gi*IN_BITS +: IN_BITS];
      assign ch_ext[gi] = {{(SUM_W-IN_BITS){raw[IN_BITS-1]}}, raw};
    end
  endgenerate

  assign bias_ext = {{(SUM_W-BIAS_BITS){bias[BIAS_BITS-1]}}, bias};

  always_comb begin
    sum = bias_ext;
    for (int c = 0; c < IN_CH; c++) begin
      sum = sum + ch_ext[c];
    end
  end

  generate
    if (SUM_W > OUT_BITS) begin : g_sat
      localparam logic signed [SUM_W-1:0] S_MAX =
        {{(SUM_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
      localparam logic signed [SUM_W-1:0] S_MIN =
        {{(SUM_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
      always_comb begin
        if (sum > S_MAX) begin
          sat = {1'b0, {(OUT_BITS-1){1'b1}}};
        end else if (sum < S_MIN) begin
          sat = {1'b1, {(OUT_BITS-1){1'b0}}};
        end else begin
          sat = sum[OUT_BITS-1:0];
        end
      end
    end else if (SUM_W == OUT_BITS) begin : g_same
      // Sum can never exceed the output range.
      assign sat = sum;
    end else begin : g_ext
      assign sat = {{(OUT_BITS-SUM_W){sum[SUM_W-1]}}, sum};
    end
  endgenerate

  assign v_d      = (relu_en && sat[OUT_BITS-1]) ? '0 : sat;
  // A pixel arriving together with frame_rst belongs to no frame.
  assign s1_val_d = in_val && !frame_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q <= 1'b0;
      v_q      <= '0;
    end else begin
      s1_val_q <= s1_val_d;
      if (s1_val_d) begin
        v_q <= v_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2: raster counters and max-pool
  // -------------------------------------------------------------------------
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PCW-1:0] px_q, px_d;
  logic [PCW-1:0] py_q, py_d;

  logic signed [OUT_BITS-1:0] hmax_q, hmax_d;
  logic signed [OUT_BITS-1:0] data_out_q, data_out_d;
  logic                       out_val_q, out_val_d;
  logic                       frame_done_q, frame_done_d;

  // Row buffer holds, per pooled column, the max of the window rows seen so
  // far. It is only a few words wide, so it is read combinationally.
  logic signed [OUT_BITS-1:0] rbuf [PW];
  logic [AW-1:0]              rd_addr;
  logic signed [OUT_BITS-1:0] rbuf_rd;

  logic                       adv;
  logic                       in_win;
  logic                       col_wrap;
  logic                       row_wrap;
  logic                       win_col_end;
  logic                       wr_en;
  logic                       emit;
  logic signed [OUT_BITS-1:0] hcur;     // max over the current window row so far
  logic signed [OUT_BITS-1:0] win_val;  // max over the current window so far

  assign rd_addr = AW'(col_q / POOL_C);
  assign rbuf_rd = rbuf[rd_addr];

  always_comb begin
    adv         = s1_val_q && !frame_rst;
    in_win      = (col_q <= COL_LIM) && (row_q <= ROW_LIM);
    col_wrap    = (col_q == COL_LAST);
    row_wrap    = (row_q == ROW_LAST);

    // At px==0 a new horizontal window starts, so any stale hmax is ignored.
    hcur        = (px_q == '0) ? v_q : smax(hmax_q, v_q);
    win_val     = (py_q == '0) ? hcur : smax(rbuf_rd, hcur);
    win_col_end = (px_q == P_LAST) && in_win;

    // The bottom row of a window only emits; the buffer entry is then dead.
    wr_en       = adv && win_col_end && (py_q != P_LAST);
    emit        = adv && win_col_end && (py_q == P_LAST);

    col_d       = col_q;
    row_d       = row_q;
    px_d        = px_q;
    py_d        = py_q;
    hmax_d      = hmax_q;

    if (frame_rst) begin
      col_d  = '0;
      row_d  = '0;
      px_d   = '0;
      py_d   = '0;
      hmax_d = '0;
    end else if (adv) begin
      hmax_d = hcur;
      col_d  = col_wrap ? '0 : col_q + 1'b1;
      px_d   = (col_wrap || (px_q == P_LAST)) ? '0 : px_q + 1'b1;
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + 1'b1;
        py_d  = (row_wrap || (py_q == P_LAST)) ? '0 : py_q + 1'b1;
      end
    end

    out_val_d    = emit;
    frame_done_d = emit && (col_q == COL_LIM) && (row_q == ROW_LIM);
    data_out_d   = emit ? win_val : data_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      hmax_q       <= '0;
      data_out_q   <= '0;
      out_val_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      px_q         <= px_d;
      py_q         <= py_d;
      hmax_q       <= hmax_d;
      data_out_q   <= data_out_d;
      out_val_q    <= out_val_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer contents need no reset: every entry is written at the top row of
  // a window before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rbuf[rd_addr] <= win_val;
    end
  end

  assign data_out   = data_out_q;
  assign out_val    = out_val_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_chan_sum_maxpool.sv
module tb_chan_sum_maxpool;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_rst;
  logic        relu_en;
  logic        in_val_a, in_val_b, in_val_c;
  logic [53:0] data_in;
  logic [7:0]  bias;

  logic [7:0]  dout_a;
  logic        oval_a, fdone_a;
  logic [19:0] dout_b;
  logic        oval_b, fdone_b;
  logic [19:0] dout_c;
  logic        oval_c, fdone_c;

  int total = 0;
  int bad   = 0;

  int qb_d[$];
  bit qb_f[$];
  int qc_d[$];
  bit qc_f[$];

  always #5 clk = ~clk;

  // 8x8, no pooling, 8-bit output: sum/bias/saturation/ReLU checks
  chan_sum_maxpool #(.WIDTH(8), .HEIGHT(8), .IN_CH(3), .IN_BITS(18),
                     .BIAS_BITS(8), .OUT_BITS(8), .POOL(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .frame_rst(frame_rst), .relu_en(relu_en),
    .in_val(in_val_a), .data_in(data_in), .bias(bias),
    .data_out(dout_a), .out_val(oval_a), .frame_done(fdone_a));

  // 8x8, 2x2 pooling
  chan_sum_maxpool #(.WIDTH(8), .HEIGHT(8), .IN_CH(3), .IN_BITS(18),
                     .BIAS_BITS(8), .OUT_BITS(20), .POOL(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .frame_rst(frame_rst), .relu_en(relu_en),
    .in_val(in_val_b), .data_in(data_in), .bias(bias),
    .data_out(dout_b), .out_val(oval_b), .frame_done(fdone_b));

  // 5x5 ragged, 2x2 pooling
  chan_sum_maxpool #(.WIDTH(5), .HEIGHT(5), .IN_CH(3), .IN_BITS(18),
                     .BIAS_BITS(8), .OUT_BITS(20), .POOL(2)) u_rg (
    .clk(clk), .rst_n(rst_n), .frame_rst(frame_rst), .relu_en(relu_en),
    .in_val(in_val_c), .data_in(data_in), .bias(bias),
    .data_out(dout_c), .out_val(oval_c), .frame_done(fdone_c));

  always @(negedge clk) begin
    if (oval_b === 1'b1) begin
      qb_d.push_back(int'($signed(dout_b)));
      qb_f.push_back(fdone_b);
    end
    if (oval_c === 1'b1) begin
      qc_d.push_back(int'($signed(dout_c)));
      qc_f.push_back(fdone_c);
    end
  end

  function automatic logic [53:0] pack3(input int a, input int b, input int c);
    return {c[17:0], b[17:0], a[17:0]};
  endfunction

  task automatic drive(input int dut, input logic [53:0] d, input logic [7:0] b);
    @(negedge clk);
    data_in  = d;
    bias     = b;
    in_val_a = (dut == 0);
    in_val_b = (dut == 1);
    in_val_c = (dut == 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_val_a = 1'b0;
      in_val_b = 1'b0;
      in_val_c = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    frame_rst = 1'b0;
    relu_en   = 1'b0;
    bias      = 8'h11;
    data_in   = pack3(50, 60, 70);
    in_val_a  = 1'b1;
    in_val_b  = 1'b1;
    in_val_c  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({oval_a, fdone_a} !== 2'b00 || dout_a !== 8'd0) begin
        bad++;
        $display("FAIL reset_p1 cyc=%0d: out_val=%b frame_done=%b data_out=%0d, required 0/0/0",
                 k, oval_a, fdone_a, dout_a);
      end
      total++;
      if ({oval_b, fdone_b} !== 2'b00 || dout_b !== 20'd0) begin
        bad++;
        $display("FAIL reset_p2 cyc=%0d: out_val=%b frame_done=%b data_out=%0d, required 0/0/0",
                 k, oval_b, fdone_b, dout_b);
      end
      total++;
      if ({oval_c, fdone_c} !== 2'b00 || dout_c !== 20'd0) begin
        bad++;
        $display("FAIL reset_rg cyc=%0d: out_val=%b frame_done=%b data_out=%0d, required 0/0/0",
                 k, oval_c, fdone_c, dout_c);
      end
    end
    in_val_a = 1'b0;
    in_val_b = 1'b0;
    in_val_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    $display("test_reset done");
  endtask

  // Columns: ch0, ch1, ch2, bias, relu_en, expected (8-bit saturated output)
  task automatic test_sum_sat();
    int tbl [10][6] = '{
      '{   5,   -2,    7,  -3, 0,    7},
      '{ 100,  100,  100,   0, 0,  127},
      '{-100, -100, -100,   0, 0, -128},
      '{-100, -100, -100,   0, 1,    0},
      '{  -5,    0,    0,   0, 0,   -5},
      '{  -5,    0,    0,   0, 1,    0},
      '{   0,    0,    0, 127, 0,  127},
      '{ -60,  -60,   -8,   0, 0, -128},
      '{ -60,  -60,   -8,  -1, 0, -128},
      '{  60,   60,    6,   0, 1,  126}
    };
    for (int i = 0; i < 10; i++) begin
      relu_en = tbl[i][4][0];
      drive(0, pack3(tbl[i][0], tbl[i][1], tbl[i][2]), 8'(tbl[i][3]));
      idle(1);
      total++;
      if (oval_a !== 1'b0) begin
        bad++;
        $display("FAIL sum_latency vec=%0d: out_val=%b one cycle after in_val, required 0", i, oval_a);
      end
      @(negedge clk);
      total++;
      if (oval_a !== 1'b1 || int'($signed(dout_a)) !== tbl[i][5]) begin
        bad++;
        $display("FAIL sum_sat vec=%0d: out_val=%b data_out=%0d, required 1/%0d",
                 i, oval_a, $signed(dout_a), tbl[i][5]);
      end
      $display("sum_sat vec=%0d data_out=%0d", i, $signed(dout_a));
    end
    relu_en = 1'b0;
    idle(2);
  endtask

  task automatic test_pool(input string name);
    int exp16 [16] = '{9, 11, 13, 15, 25, 27, 29, 31,
                       41, 43, 45, 47, 57, 59, 61, 63};
    relu_en = 1'b0;
    qb_d.delete();
    qb_f.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        drive(1, pack3(r * 8 + c, 0, 0), 8'd0);
      end
    end
    idle(4);
    total++;
    if (qb_d.size() != 16) begin
      bad++;
      $display("FAIL %s_count: outputs=%0d, required 16", name, qb_d.size());
    end
    for (int k = 0; k < 16 && k < qb_d.size(); k++) begin
      total++;
      if (qb_d[k] !== exp16[k] || qb_f[k] !== (k == 15)) begin
        bad++;
        $display("FAIL %s out=%0d: data_out=%0d frame_done=%b, required %0d/%b",
                 name, k, qb_d[k], qb_f[k], exp16[k], (k == 15));
      end
      $display("%s out=%0d data_out=%0d frame_done=%b", name, k, qb_d[k], qb_f[k]);
    end
  endtask

  task automatic test_ragged();
    int exp4 [4] = '{5, 4, 5, 4};
    int v;
    relu_en = 1'b0;
    qc_d.delete();
    qc_f.delete();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        // Ragged column/row get a dominating value so any leak would show.
        v = (r == 4 || c == 4) ? 100 : ((7 * r + 3 * c) % 11) - 5;
        drive(2, pack3(v, 0, 0), 8'd0);
        idle($urandom_range(0, 3));
      end
    end
    idle(5);
    total++;
    if (qc_d.size() != 4) begin
      bad++;
      $display("FAIL ragged_count: outputs=%0d, required 4", qc_d.size());
    end
    for (int k = 0; k < 4 && k < qc_d.size(); k++) begin
      total++;
      if (qc_d[k] !== exp4[k] || qc_f[k] !== (k == 3)) begin
        bad++;
        $display("FAIL ragged out=%0d: data_out=%0d frame_done=%b, required %0d/%b",
                 k, qc_d[k], qc_f[k], exp4[k], (k == 3));
      end
      $display("ragged out=%0d data_out=%0d frame_done=%b", k, qc_d[k], qc_f[k]);
    end
  endtask

  task automatic test_frame_rst();
    qb_d.delete();
    qb_f.delete();
    for (int k = 0; k < 13; k++) begin
      drive(1, pack3(1000, 0, 0), 8'd0);
    end
    @(negedge clk);
    frame_rst = 1'b1;
    in_val_b  = 1'b1;
    #1;
    total++;
    if (qb_d.size() != 2) begin
      bad++;
      $display("FAIL frst_pre: outputs before restart=%0d, required 2", qb_d.size());
    end
    qb_d.delete();
    qb_f.delete();
    @(negedge clk);
    frame_rst = 1'b0;
    in_val_b  = 1'b0;
    idle(4);
    total++;
    if (qb_d.size() != 0) begin
      bad++;
      $display("FAIL frst_stale: outputs after restart=%0d, required 0", qb_d.size());
    end
    $display("frame_rst stale outputs=%0d", qb_d.size());
    test_pool("post_frst");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, pack3(1000, 0, 0), 8'd0);
    end
    @(negedge clk);
    in_val_b = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dout_b !== 20'd0 || oval_b !== 1'b0) begin
      bad++;
      $display("FAIL arst_immediate: data_out=%0d out_val=%b, required 0/0", dout_b, oval_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    test_pool("post_arst");
  endtask

  initial begin
    test_reset();
    test_sum_sat();
    test_pool("pool_f1");
    test_pool("pool_wrap");
    test_ragged();
    test_frame_rst();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
